// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq_if
// Description : Request/result bundle of the sequential binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;

    modport master (output start, bin, input  busy, done, bcd, ovf);
    modport slave  (input  start, bin, output busy, done, bcd, ovf);
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : 16-bit binary to 4-digit packed BCD, double-dabble, 1 bit/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter bit SATURATE = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    bin2bcd_seq_if.slave   bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;
    localparam logic [3:0] c_LAST_BIT = 4'd15;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_bin_sr;
    logic [19:0] r_scratch;
    logic [3:0]  r_cnt;
    logic [15:0] r_bcd;
    logic        r_ovf;
    logic        r_done;

    logic        w_busy;
    logic        w_load;
    logic        w_shift;
    logic        w_finish;
    logic        w_ovf;
    logic [19:0] w_adj;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.start) w_state_nxt = c_ST_SHIFT;
            c_ST_SHIFT: if (r_cnt == c_LAST_BIT) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_busy   = (r_state != c_ST_IDLE);
        w_load   = (r_state == c_ST_IDLE) && bus.start;
        w_shift  = (r_state == c_ST_SHIFT);
        w_finish = (r_state == c_ST_DONE);
    end

    // Add-3 correction on every digit in parallel; digits never carry into each other
    for (genvar gi = 0; gi < 5; gi++) begin : g_digit
        assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                  (r_scratch[4*gi +: 4] + 4'd3) :
                                  r_scratch[4*gi +: 4];
    end

    assign w_ovf = (r_scratch[19:16] != 4'd0) || (r_scratch[15:0] > 16'h9999);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin_sr  <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_bin_sr  <= bus.bin;
                r_scratch <= '0;
                r_cnt     <= '0;
            end else if (w_shift) begin
                {r_scratch, r_bin_sr} <= {w_adj, r_bin_sr} << 1;
                r_cnt                 <= r_cnt + 4'd1;
            end else if (w_finish) begin
                r_ovf  <= w_ovf;
                r_bcd  <= (SATURATE && w_ovf) ? 16'h9999 : r_scratch[15:0];
                r_done <= 1'b1;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Scoreboard bench driving a saturating and a wrapping converter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin = 16'd0;

    always #5 clk = ~clk;

    bin2bcd_seq_if if_s ();
    bin2bcd_seq_if if_n ();

    assign if_s.start = start;
    assign if_s.bin   = bin;
    assign if_n.start = start;
    assign if_n.bin   = bin;

    bin2bcd_seq #(.SATURATE(1'b1)) u_dut_sat (.clk(clk), .reset(reset), .bus(if_s.slave));
    bin2bcd_seq #(.SATURATE(1'b0)) u_dut_wrap (.clk(clk), .reset(reset), .bus(if_n.slave));

    int n_checks = 0;
    int n_errors = 0;
    int cycle = 0;
    int done_cnt = 0;
    int last_done_cycle = 0;
    int prev_done_cycle = 0;
    int target = 0;
    logic [16:0] q_s[$];
    logic [16:0] q_n[$];
    logic [16:0] r_exp_s;
    logic [16:0] r_exp_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, bcd} from integer decimal arithmetic
    function automatic logic [16:0] model(input int v, input bit sat);
        bit o;
        int d;
        o = (v > 9999);
        d = o ? (sat ? 9999 : v % 10000) : v;
        return {o, 4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (if_s.done) begin
            if (q_s.size() == 0) begin
                check("sat_unexpected_done", 32'(q_s.size()), 32'd1);
            end else begin
                r_exp_s = q_s.pop_front();
                check("sat_bcd", {16'd0, if_s.bcd}, {16'd0, r_exp_s[15:0]});
                check("sat_ovf", {31'd0, if_s.ovf}, {31'd0, r_exp_s[16]});
            end
            done_cnt++;
            prev_done_cycle = last_done_cycle;
            last_done_cycle = cycle;
        end
        if (if_n.done) begin
            if (q_n.size() == 0) begin
                check("wrap_unexpected_done", 32'(q_n.size()), 32'd1);
            end else begin
                r_exp_n = q_n.pop_front();
                check("wrap_bcd", {16'd0, if_n.bcd}, {16'd0, r_exp_n[15:0]});
                check("wrap_ovf", {31'd0, if_n.ovf}, {31'd0, r_exp_n[16]});
            end
        end
    end

    // Pulse start for one cycle; returns #1 after the sampling edge
    task automatic issue(input int v, input bit accept);
        @(posedge clk);
        #1;
        start = 1'b1;
        bin   = 16'(v);
        if (accept) begin
            q_s.push_back(model(v, 1'b1));
            q_n.push_back(model(v, 1'b0));
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int tgt);
        int k;
        k = 0;
        while (done_cnt < tgt && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("wait_done", 32'(done_cnt), 32'(tgt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int all_busy;
        int any_done;
        int seq[5] = '{0, 9999, 10000, 65535, 10007};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, if_s.busy}, 32'd0);
        check("rst_done", {31'd0, if_s.done}, 32'd0);
        check("rst_bcd", {16'd0, if_s.bcd}, 32'd0);
        check("rst_ovf", {31'd0, if_n.ovf}, 32'd0);
        reset = 1'b0;

        // Latency: busy across E0..E16, done and busy fall at E17
        issue(1234, 1'b1);
        check("busy_e0", {31'd0, if_s.busy}, 32'd1);
        all_busy = 1;
        any_done = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (!if_s.busy) all_busy = 0;
            if (if_s.done) any_done = 1;
        end
        check("busy_e1_e16", 32'(all_busy), 32'd1);
        check("no_early_done", 32'(any_done), 32'd0);
        @(posedge clk);
        #1;
        check("busy_e17", {31'd0, if_s.busy}, 32'd0);
        check("done_e17", {31'd0, if_s.done}, 32'd1);
        target++;
        wait_done(target);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, if_s.done}, 32'd0);

        foreach (seq[i]) begin
            issue(seq[i], 1'b1);
            target++;
            wait_done(target);
        end

        // Start while busy is dropped
        issue(42, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        bin   = 16'd777;
        @(posedge clk);
        #1;
        start = 1'b0;
        target++;
        wait_done(target);
        repeat (25) @(posedge clk);
        #1;
        check("ignored_start", 32'(done_cnt), 32'(target));
        issue(777, 1'b1);
        target++;
        wait_done(target);

        // Start held high: fresh bin taken at each IDLE edge, 18-cycle period
        @(posedge clk);
        #1;
        start = 1'b1;
        bin   = 16'd111;
        q_s.push_back(model(111, 1'b1));
        q_n.push_back(model(111, 1'b0));
        @(posedge clk);
        #1;
        bin = 16'd222;
        q_s.push_back(model(222, 1'b1));
        q_n.push_back(model(222, 1'b0));
        target++;
        wait_done(target);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_rearm", {31'd0, if_s.busy}, 32'd1);
        target++;
        wait_done(target);
        check("b2b_period", 32'(last_done_cycle - prev_done_cycle), 32'd18);

        // Reset aborts a conversion in flight
        issue(1234, 1'b1);
        target++;
        wait_done(target);
        issue(5678, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, if_s.busy}, 32'd0);
        check("abort_bcd_sat", {16'd0, if_s.bcd}, 32'd0);
        check("abort_bcd_wrap", {16'd0, if_n.bcd}, 32'd0);
        check("abort_done", {31'd0, if_s.done}, 32'd0);
        reset = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'(target));

        // Reset wins over a simultaneous start
        reset = 1'b1;
        start = 1'b1;
        bin   = 16'd100;
        @(posedge clk);
        #1;
        check("rst_start_busy", {31'd0, if_s.busy}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_start_idle", {31'd0, if_n.busy}, 32'd0);
        check("queue_empty", 32'(q_s.size() + q_n.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
